sad_datapath: RTL and testbench

SAD_DATAPATH -- requirements
Module: sad_datapath

---
 rtl/sad_datapath_pkg.sv | 10 +
 rtl/sad_absdiff.sv | 14 +
 rtl/sad_datapath.sv | 58 +++++
 tb/tb_sad_datapath.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sad_datapath_pkg.sv
// sad_datapath_pkg: shared block-size defaults and the abs-diff width helper.
package sad_datapath_pkg;
  localparam int N_DEF  = 16;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = $clog2(N_DEF);
  localparam int SW_DEF = DW_DEF + AW_DEF;
  function automatic int ad_w(input int dw);
    return dw + 1;
  endfunction
endpackage

// File: rtl/sad_absdiff.sv
// sad_absdiff: combinational |a - b| of two unsigned pixels.
module sad_absdiff
  import sad_datapath_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] d
);
  logic [ad_w(DW)-1:0] diff;
  assign diff = {1'b0, a} - {1'b0, b};
  assign d = diff[DW] ? b - a : diff[DW-1:0];
endmodule

// File: rtl/sad_datapath.sv
// sad_datapath: counts pixel pairs, accumulates |a-b| and captures the block SAD.
module sad_datapath
  import sad_datapath_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                         clk,
  input  logic                         Mrst_n,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         en_reg,
  output logic [$clog2(N)-1:0]         addr,
  input  logic [DW-1:0]                a_data,
  input  logic [DW-1:0]                b_data,
  output logic                         comp,
  output logic [DW+$clog2(N)-1:0]      sad_out,
  output logic                         sad_valid,
  output logic                         done
);
  localparam int AW = $clog2(N);
  localparam int SW = DW + AW;
  localparam logic [AW:0] N_CNT = (AW+1)'(N);
  logic [AW:0]   cnt;
  logic [SW-1:0] sum;
  logic          rd_v;
  logic [DW-1:0] ad;
  logic [SW-1:0] term;
  logic          accept;
  sad_absdiff #(.DW(DW)) u_absdiff (.a(a_data), .b(b_data), .d(ad));
  assign comp   = cnt == N_CNT;
  assign addr   = cnt[AW-1:0];
  assign accept = en && !rst && !comp;
  assign term   = rd_v ? {{AW{1'b0}}, ad} : '0;
  always_ff @(posedge clk or negedge Mrst_n) begin
    if (!Mrst_n) begin
      cnt  <= '0;
      rd_v <= 1'b0;
      sum  <= '0;
    end else begin
      cnt  <= rst ? '0 : accept ? cnt + 1'b1 : cnt;
      rd_v <= accept;
      sum  <= rst ? '0 : sum + term;
    end
  end
  // capture sees the in-flight term so en_reg may follow the last en directly
  always_ff @(posedge clk or negedge Mrst_n) begin
    if (!Mrst_n) begin
      sad_out   <= '0;
      sad_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      sad_out   <= en_reg ? sum + term : sad_out;
      sad_valid <= rst ? 1'b0 : en_reg ? 1'b1 : sad_valid;
      done      <= en_reg;
    end
  end
endmodule

// File: tb/tb_sad_datapath.sv
// tb_sad_datapath: directed vectors with hand-computed SAD results.
module tb_sad_datapath;
  logic        clk;
  logic        Mrst_n;
  logic        rst;
  logic        en;
  logic        en_reg;
  logic [3:0]  addr;
  logic [7:0]  a_data;
  logic [7:0]  b_data;
  logic        comp;
  logic [11:0] sad_out;
  logic        sad_valid;
  logic        done;
  logic [7:0]  mem_a [16];
  logic [7:0]  mem_b [16];
  int n_cmp = 0;
  int n_bad = 0;

  sad_datapath dut (
    .clk(clk), .Mrst_n(Mrst_n), .rst(rst), .en(en), .en_reg(en_reg),
    .addr(addr), .a_data(a_data), .b_data(b_data), .comp(comp),
    .sad_out(sad_out), .sad_valid(sad_valid), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_data <= mem_a[addr];
    b_data <= mem_b[addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_en(input int k);
    en = 1'b1;
    for (int i = 0; i < k; i++) tick();
    en = 1'b0;
  endtask

  task automatic capture();
    en_reg = 1'b1;
    tick();
    en_reg = 1'b0;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = mode == 0 ? 8'd10 : mode == 1 ? 8'd255 : 8'(i);
      mem_b[i] = mode == 0 ? 8'd3  : mode == 1 ? 8'd0   : 8'(15 - i);
    end
  endtask

  initial begin
    clk = 1'b0; Mrst_n = 1'b0; rst = 1'b0; en = 1'b0; en_reg = 1'b0;
    fill(0);
    #12;
    check("rst_sad_out", 32'(sad_out), 0);
    check("rst_valid", 32'(sad_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_comp", 32'(comp), 0);
    tick();
    Mrst_n = 1'b1;

    clear();
    run_en(15);
    check("comp_early", 32'(comp), 0);
    run_en(1);
    check("comp_full", 32'(comp), 1);
    capture();
    check("sad_10_3", 32'(sad_out), 112);
    check("done_hi", 32'(done), 1);
    check("valid_hi", 32'(sad_valid), 1);
    tick();
    check("done_pulse", 32'(done), 0);
    check("valid_hold", 32'(sad_valid), 1);

    run_en(1);
    check("sat_comp", 32'(comp), 1);
    check("sat_addr", 32'(addr), 0);
    tick(); tick();
    capture();
    check("sat_sum", 32'(sad_out), 112);
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    check("rst_en_comp", 32'(comp), 0);
    check("rst_en_valid", 32'(sad_valid), 0);
    tick();
    check("rst_en_addr", 32'(addr), 0);
    capture();
    check("empty_sad", 32'(sad_out), 0);

    fill(1);
    clear();
    run_en(16);
    tick(); tick(); tick();
    capture();
    check("sad_max", 32'(sad_out), 4080);
    rst = 1'b1; en_reg = 1'b1;
    tick();
    rst = 1'b0; en_reg = 1'b0;
    check("rst_cap_sad", 32'(sad_out), 4080);
    check("rst_cap_valid", 32'(sad_valid), 0);
    capture();
    check("rst_cap_clear", 32'(sad_out), 0);

    fill(2);
    clear();
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("addr_%0d", i), 32'(addr), 32'(i));
      tick();
    end
    en = 1'b0;
    capture();
    check("bypass_sad", 32'(sad_out), 128);
    tick(); tick(); tick();
    capture();
    check("late_sad", 32'(sad_out), 128);

    clear();
    run_en(7);
    check("mid_addr", 32'(addr), 7);
    Mrst_n = 1'b0;
    #1;
    check("async_sad_out", 32'(sad_out), 0);
    check("async_valid", 32'(sad_valid), 0);
    check("async_addr", 32'(addr), 0);
    check("async_comp", 32'(comp), 0);
    check("async_done", 32'(done), 0);
    @(posedge clk);
    #1;
    Mrst_n = 1'b1;
    run_en(16);
    capture();
    check("post_reset_sad", 32'(sad_out), 128);

    clear();
    run_en(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    capture();
    check("rst_inflight", 32'(sad_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
